// File: rtl/mmu_tlb_pkg.sv
// mmu_tlb_pkg: shared definitions for the MMU/TLB block.
// Holds the kseg0/kseg1 window bounds, EntryHi/EntryLo field positions,
// TLB geometry, the FSM state encoding, the TLB entry layout and helpers
// that build an entry from CP0 words and classify unmapped addresses.
// Build option: MMU_MCHECK_EN (used by mmu_tlb and tlb_cam) enables
// multi-hit machine-check reporting.
package mmu_tlb_pkg;

    // TLB geometry
    localparam int TLB_SIZE  = 16;
    localparam int TLB_IDX_W = 4;

    // kseg0/kseg1 unmapped window and physical mask
    localparam logic [31:0] KSEG_LO    = 32'h8000_0000;
    localparam logic [31:0] KSEG_HI    = 32'hBFFF_FFFF;
    localparam logic [31:0] KSEG_PMASK = 32'h1FFF_FFFF;

    // EntryHi fields
    localparam int EHI_VPN2_MSB = 31;
    localparam int EHI_VPN2_LSB = 13;
    localparam int EHI_ASID_MSB = 7;
    localparam int EHI_ASID_LSB = 0;

    // EntryLo fields
    localparam int ELO_PFN_MSB = 25;
    localparam int ELO_PFN_LSB = 6;
    localparam int ELO_D_BIT   = 2;
    localparam int ELO_V_BIT   = 1;
    localparam int ELO_G_BIT   = 0;

    // Request FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // One TLB entry: an even/odd page pair sharing VPN2/ASID/G
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // Assemble an entry from the CP0 EntryHi/EntryLo0/EntryLo1 words.
    // The entry is global only when both halves carry G.
    function automatic tlb_entry_t make_entry(input logic [31:0] hi,
                                              input logic [31:0] lo0,
                                              input logic [31:0] lo1);
        tlb_entry_t e;
        e.vpn2 = hi[EHI_VPN2_MSB:EHI_VPN2_LSB];
        e.asid = hi[EHI_ASID_MSB:EHI_ASID_LSB];
        e.g    = lo0[ELO_G_BIT] & lo1[ELO_G_BIT];
        e.pfn0 = lo0[ELO_PFN_MSB:ELO_PFN_LSB];
        e.d0   = lo0[ELO_D_BIT];
        e.v0   = lo0[ELO_V_BIT];
        e.pfn1 = lo1[ELO_PFN_MSB:ELO_PFN_LSB];
        e.d1   = lo1[ELO_D_BIT];
        e.v1   = lo1[ELO_V_BIT];
        return e;
    endfunction

    // True for kseg0/kseg1 addresses, which bypass the TLB.
    function automatic logic is_unmapped(input logic [31:0] addr);
        return (addr >= KSEG_LO) && (addr <= KSEG_HI);
    endfunction

endpackage

// File: rtl/mmu_tlb_if.sv
// mmu_tlb_if: request/response bundle between the RAM adapter and the MMU.
// Signals keep the MMU-side names: ce_i/we_i/addr_i/data_i flow into the
// MMU, ready_o/tlb_err_o/mod_o/mcheck_o/data_o flow back.
// master = RAM adapter side, slave = MMU side.
interface mmu_tlb_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        tlb_err_o;
    logic        mod_o;
    logic        mcheck_o;
    logic [31:0] data_o;

    modport master (
        output ce_i, we_i, addr_i, data_i,
        input  ready_o, tlb_err_o, mod_o, mcheck_o, data_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, data_i,
        output ready_o, tlb_err_o, mod_o, mcheck_o, data_o
    );
endinterface

// File: rtl/mmu_tlb_tlb_cam.sv
// tlb_cam: 16-entry TLB array with a CP0 write port and combinational match.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   tlbw_i, tlb_index_i      - write strobe and target entry
//   tlb_entryhi_i/lo0_i/lo1_i- CP0 words for the written entry
//   vpn2_i, odd_i, asid_i    - lookup key (VA[31:13], VA[12], current ASID)
//   hit_o, pfn_o, d_o, v_o   - lowest-index hit and its selected half
//   multi_o                  - more than one entry matched (MMU_MCHECK_EN only)
// Lookups read the registered array, so a write on the same edge is not
// visible to a lookup in that cycle.
module tlb_cam
    import mmu_tlb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tlbw_i,
    input  logic [TLB_IDX_W-1:0] tlb_index_i,
    input  logic [31:0]          tlb_entryhi_i,
    input  logic [31:0]          tlb_entrylo0_i,
    input  logic [31:0]          tlb_entrylo1_i,
    input  logic [18:0]          vpn2_i,
    input  logic                 odd_i,
    input  logic [7:0]           asid_i,
    output logic                 hit_o,
    output logic [19:0]          pfn_o,
    output logic                 d_o,
    output logic                 v_o
`ifdef MMU_MCHECK_EN
    ,
    output logic                 multi_o
`endif
);

    tlb_entry_t             entries_q [TLB_SIZE];
    tlb_entry_t             entries_d [TLB_SIZE];
    logic [TLB_SIZE-1:0]    match_s;
    logic [TLB_IDX_W-1:0]   hit_idx_s;

    // Next array contents: copy, then overwrite the indexed entry on tlbw
    always_comb begin
        for (int i = 0; i < TLB_SIZE; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (tlbw_i) begin
            entries_d[tlb_index_i] = make_entry(tlb_entryhi_i, tlb_entrylo0_i, tlb_entrylo1_i);
        end else begin
            entries_d[tlb_index_i] = entries_q[tlb_index_i];
        end
    end

    // Entry storage; reset wipes every entry and wins over a concurrent tlbw
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    // Per-entry match. An entry with both halves invalid is treated as empty,
    // so a freshly reset TLB misses everywhere and never reports multi-hit.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < TLB_SIZE; i++) begin
            match_s[i] = (entries_q[i].v0 | entries_q[i].v1) &&
                         (entries_q[i].vpn2 == vpn2_i) &&
                         (entries_q[i].g || (entries_q[i].asid == asid_i));
        end
    end

    // Priority encoder: scanning downwards leaves the lowest matching index
    always_comb begin
        hit_idx_s = '0;
        for (int i = TLB_SIZE - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                hit_idx_s = TLB_IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Even/odd page selection from the winning entry
    always_comb begin
        hit_o = |match_s;
        if (odd_i) begin
            pfn_o = entries_q[hit_idx_s].pfn1;
            d_o   = entries_q[hit_idx_s].d1;
            v_o   = entries_q[hit_idx_s].v1;
        end else begin
            pfn_o = entries_q[hit_idx_s].pfn0;
            d_o   = entries_q[hit_idx_s].d0;
            v_o   = entries_q[hit_idx_s].v0;
        end
    end

`ifdef MMU_MCHECK_EN
    logic [4:0] match_cnt_s;

    // Population count of matches for multi-hit detection
    always_comb begin
        match_cnt_s = 5'd0;
        for (int i = 0; i < TLB_SIZE; i++) begin
            match_cnt_s = match_cnt_s + {4'd0, match_s[i]};
        end
        multi_o = (match_cnt_s > 5'd1);
    end
`endif

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: MIPS-style MMU between a RAM adapter and the physical bus.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   ram (mmu_tlb_if.slave)    - ce/we/addr/data request, ready/tlb_err/mod/
//                               mcheck status and read data
//   asid_i, tlbw_i, tlb_index_i, tlb_entryhi_i, tlb_entrylo0_i,
//   tlb_entrylo1_i            - CP0 current ASID and TLB write port
//   bus_ce_o, bus_we_o, bus_addr_o, bus_data_o, bus_data_i, bus_ack_i
//                             - physical memory bus
// Flow: IDLE latches a request, LOOKUP translates in one cycle and either
// faults straight to DONE or launches a bus cycle, ACCESS waits for ack,
// DONE holds the result while the same request stays presented.
// Build option: define MMU_MCHECK_EN to raise mcheck_o on a multi-hit;
// otherwise mcheck_o stays 0 and the lowest matching entry is used.
module mmu_tlb
    import mmu_tlb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mmu_tlb_if.slave             ram,
    input  logic [7:0]           asid_i,
    input  logic                 tlbw_i,
    input  logic [TLB_IDX_W-1:0] tlb_index_i,
    input  logic [31:0]          tlb_entryhi_i,
    input  logic [31:0]          tlb_entrylo0_i,
    input  logic [31:0]          tlb_entrylo1_i,
    output logic                 bus_ce_o,
    output logic                 bus_we_o,
    output logic [31:0]          bus_addr_o,
    output logic [31:0]          bus_data_o,
    input  logic [31:0]          bus_data_i,
    input  logic                 bus_ack_i
);

    state_e      state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic        we_q,       we_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        ready_q,    ready_d;
    logic        err_q,      err_d;
    logic        mod_q,      mod_d;
    logic        mcheck_q,   mcheck_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        bus_ce_q,   bus_ce_d;
    logic        bus_we_q,   bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_data_q, bus_data_d;

    logic        hit_s;
    logic [19:0] pfn_s;
    logic        d_s;
    logic        v_s;
    logic        unmapped_s;
    logic [31:0] phys_s;
    logic        multi_fault_s;

    // Lookup always uses the latched address, never the live addr_i
    tlb_cam u_cam (
        .clk            (clk),
        .rst            (rst),
        .tlbw_i         (tlbw_i),
        .tlb_index_i    (tlb_index_i),
        .tlb_entryhi_i  (tlb_entryhi_i),
        .tlb_entrylo0_i (tlb_entrylo0_i),
        .tlb_entrylo1_i (tlb_entrylo1_i),
        .vpn2_i         (addr_q[31:13]),
        .odd_i          (addr_q[12]),
        .asid_i         (asid_i),
        .hit_o          (hit_s),
        .pfn_o          (pfn_s),
        .d_o            (d_s),
        .v_o            (v_s)
`ifdef MMU_MCHECK_EN
        ,
        .multi_o        (multi_fault_s)
`endif
    );

`ifndef MMU_MCHECK_EN
    // Without machine-check support the multi-hit condition never fires,
    // so mcheck_q can never leave its reset value of 0.
    assign multi_fault_s = 1'b0;
`endif

    // Address translation of the latched request
    always_comb begin
        unmapped_s = is_unmapped(addr_q);
        if (unmapped_s) begin
            phys_s = addr_q & KSEG_PMASK;
        end else begin
            phys_s = {pfn_s, addr_q[11:0]};
        end
    end

    // Next-state and output logic; every register holds unless changed
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        err_d      = err_q;
        mod_d      = mod_q;
        mcheck_d   = mcheck_q;
        rdata_d    = rdata_q;
        bus_ce_d   = bus_ce_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;

        case (state_q)
            ST_IDLE: begin
                if (ram.ce_i) begin
                    addr_d  = ram.addr_i;
                    we_d    = ram.we_i;
                    wdata_d = ram.data_i;
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOOKUP: begin
                // Faults finish here with data_o left at 0 and no bus cycle
                if (!unmapped_s && multi_fault_s) begin
                    mcheck_d = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = ST_DONE;
                end else if (!unmapped_s && (!hit_s || !v_s)) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else if (!unmapped_s && we_q && !d_s) begin
                    mod_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    bus_ce_d   = 1'b1;
                    bus_we_d   = we_q;
                    bus_addr_d = phys_s;
                    bus_data_d = wdata_q;
                    state_d    = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // ce_i is deliberately ignored here: an issued cycle always completes
                if (bus_ack_i) begin
                    rdata_d  = we_q ? 32'd0 : bus_data_i;
                    bus_ce_d = 1'b0;
                    bus_we_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end

            ST_DONE: begin
                // Result is held only while the very same request is presented
                if (ram.ce_i && (ram.addr_i == addr_q) && (ram.we_i == we_q)) begin
                    state_d = ST_DONE;
                end else begin
                    ready_d    = 1'b0;
                    err_d      = 1'b0;
                    mod_d      = 1'b0;
                    mcheck_d   = 1'b0;
                    rdata_d    = 32'd0;
                    bus_addr_d = 32'd0;
                    bus_data_d = 32'd0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            mod_q      <= 1'b0;
            mcheck_q   <= 1'b0;
            rdata_q    <= 32'd0;
            bus_ce_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 32'd0;
            bus_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            mod_q      <= mod_d;
            mcheck_q   <= mcheck_d;
            rdata_q    <= rdata_d;
            bus_ce_q   <= bus_ce_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
        end
    end

    assign ram.ready_o   = ready_q;
    assign ram.tlb_err_o = err_q;
    assign ram.mod_o     = mod_q;
    assign ram.mcheck_o  = mcheck_q;
    assign ram.data_o    = rdata_q;
    assign bus_ce_o      = bus_ce_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_data_o    = bus_data_q;

endmodule

// File: tb/tb_mmu_tlb.sv
module tb_mmu_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  asid;
    logic        tlbw;
    logic [3:0]  tlb_idx;
    logic [31:0] ehi, elo0, elo1;
    logic        bus_ce, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        ce_seen;
    int          total_cnt = 0;
    int          pass_cnt  = 0;

    always #5 clk = ~clk;

    mmu_tlb_if ram_if ();

    mmu_tlb dut (
        .clk            (clk),
        .rst            (rst),
        .ram            (ram_if),
        .asid_i         (asid),
        .tlbw_i         (tlbw),
        .tlb_index_i    (tlb_idx),
        .tlb_entryhi_i  (ehi),
        .tlb_entrylo0_i (elo0),
        .tlb_entrylo1_i (elo1),
        .bus_ce_o       (bus_ce),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_data_o     (bus_wdata),
        .bus_data_i     (bus_rdata),
        .bus_ack_i      (bus_ack)
    );

    // Records whether any bus cycle was issued since last cleared
    always @(negedge clk) if (bus_ce) ce_seen = 1'b1;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task tlb_write(input logic [3:0] idx, input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        tlb_idx = idx; ehi = hi; elo0 = lo0; elo1 = lo1; tlbw = 1'b1;
        tick;
        tlbw = 1'b0;
    endtask

    task req(input logic we, input logic [31:0] addr, input logic [31:0] data);
        ram_if.we_i = we; ram_if.addr_i = addr; ram_if.data_i = data; ram_if.ce_i = 1'b1;
    endtask

    task end_req;
        ram_if.ce_i = 1'b0;
        repeat (3) tick;
    endtask

    task test_reset;
        rst = 1'b1;
        repeat (2) tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.tlb_err_o, ram_if.mod_o, ram_if.mcheck_o, bus_ce, bus_we} !== 6'b000000)
            $display("FAIL reset_flags: got %b exp 000000", {ram_if.ready_o, ram_if.tlb_err_o, ram_if.mod_o, ram_if.mcheck_o, bus_ce, bus_we});
        else pass_cnt++;
        total_cnt++;
        if ({bus_addr, bus_wdata, ram_if.data_o} !== 96'd0)
            $display("FAIL reset_data: got %h exp 0", {bus_addr, bus_wdata, ram_if.data_o});
        else pass_cnt++;
        rst = 1'b0;
        tick;
    endtask

    task test_unmapped_read;
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        req(1'b0, 32'h8000_1000, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if ({bus_ce, bus_we, bus_addr, ram_if.ready_o} !== {1'b1, 1'b0, 32'h0000_1000, 1'b0})
            $display("FAIL kseg0_bus: got ce=%b we=%b addr=%h rdy=%b exp ce=1 we=0 addr=00001000 rdy=0", bus_ce, bus_we, bus_addr, ram_if.ready_o);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.data_o, bus_ce} !== {1'b1, 32'hDEADBEEF, 1'b0})
            $display("FAIL kseg0_done: got rdy=%b data=%h ce=%b exp rdy=1 data=deadbeef ce=0", ram_if.ready_o, ram_if.data_o, bus_ce);
        else pass_cnt++;
        bus_rdata = 32'h0;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.data_o} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL done_hold: got rdy=%b data=%h exp rdy=1 data=deadbeef", ram_if.ready_o, ram_if.data_o);
        else pass_cnt++;
        ram_if.ce_i = 1'b0;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.data_o} !== 33'd0)
            $display("FAIL done_exit: got rdy=%b data=%h exp 0", ram_if.ready_o, ram_if.data_o);
        else pass_cnt++;
        tick;
    endtask

    task test_unmapped_write;
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        req(1'b1, 32'hBFC0_0040, 32'hCAFE_F00D);
        repeat (2) tick;
        total_cnt++;
        if ({bus_ce, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 32'h1FC0_0040, 32'hCAFE_F00D})
            $display("FAIL kseg1_write_bus: got ce=%b we=%b addr=%h wd=%h exp 1 1 1fc00040 cafef00d", bus_ce, bus_we, bus_addr, bus_wdata);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.data_o} !== {1'b1, 32'd0})
            $display("FAIL kseg1_write_done: got rdy=%b data=%h exp rdy=1 data=0", ram_if.ready_o, ram_if.data_o);
        else pass_cnt++;
        end_req;
    endtask

    task test_mapped;
        tlb_write(4'd3, 32'h0040_0005, 32'h0, 32'h0000_48C6);
        asid = 8'd5; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        req(1'b0, 32'h0040_1ABC, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if ({bus_ce, bus_addr} !== {1'b1, 32'h0012_3ABC})
            $display("FAIL mapped_odd_addr: got ce=%b addr=%h exp ce=1 addr=00123abc", bus_ce, bus_addr);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.tlb_err_o, ram_if.data_o} !== {1'b1, 1'b0, 32'h1234_5678})
            $display("FAIL mapped_done: got rdy=%b err=%b data=%h exp 1 0 12345678", ram_if.ready_o, ram_if.tlb_err_o, ram_if.data_o);
        else pass_cnt++;
        end_req;
        ce_seen = 1'b0;
        req(1'b0, 32'h0040_0ABC, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.tlb_err_o, ram_if.data_o, ce_seen} !== {1'b1, 1'b1, 32'd0, 1'b0})
            $display("FAIL even_invalid: got rdy=%b err=%b data=%h bus=%b exp 1 1 0 0", ram_if.ready_o, ram_if.tlb_err_o, ram_if.data_o, ce_seen);
        else pass_cnt++;
        end_req;
    endtask

    task test_asid_miss;
        asid = 8'd6; ce_seen = 1'b0;
        req(1'b0, 32'h0040_1ABC, 32'd0);
        tick;
        total_cnt++;
        if (ram_if.ready_o !== 1'b0)
            $display("FAIL asid_miss_early: got rdy=%b exp 0", ram_if.ready_o);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.tlb_err_o, ram_if.mod_o, ram_if.data_o, ce_seen} !== {3'b110, 32'd0, 1'b0})
            $display("FAIL asid_miss: got rdy=%b err=%b mod=%b data=%h bus=%b exp 1 1 0 0 0", ram_if.ready_o, ram_if.tlb_err_o, ram_if.mod_o, ram_if.data_o, ce_seen);
        else pass_cnt++;
        end_req;
        asid = 8'd5;
    endtask

    task test_mod;
        tlb_write(4'd4, 32'h0060_0005, 32'h0001_1582, 32'h0);
        ce_seen = 1'b0;
        req(1'b1, 32'h0060_0010, 32'hAAAA_5555);
        repeat (2) tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.tlb_err_o, ram_if.mod_o, ce_seen} !== 4'b1010)
            $display("FAIL mod_fault: got rdy=%b err=%b mod=%b bus=%b exp 1 0 1 0", ram_if.ready_o, ram_if.tlb_err_o, ram_if.mod_o, ce_seen);
        else pass_cnt++;
        end_req;
        total_cnt++;
        if (ram_if.mod_o !== 1'b0)
            $display("FAIL mod_cleared: got %b exp 0", ram_if.mod_o);
        else pass_cnt++;
        req(1'b0, 32'h0060_0010, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if ({bus_ce, bus_addr} !== {1'b1, 32'h0045_6010})
            $display("FAIL clean_read: got ce=%b addr=%h exp ce=1 addr=00456010", bus_ce, bus_addr);
        else pass_cnt++;
        end_req;
    endtask

    task test_global;
        tlb_write(4'd5, 32'h0070_0009, 32'h0000_2AC3, 32'h0000_0001);
        asid = 8'd6;
        req(1'b0, 32'h0070_0004, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if ({bus_ce, bus_addr} !== {1'b1, 32'h000A_B004})
            $display("FAIL global_hit: got ce=%b addr=%h exp ce=1 addr=000ab004", bus_ce, bus_addr);
        else pass_cnt++;
        end_req;
        asid = 8'd5;
    endtask

    task test_multi;
        tlb_write(4'd6, 32'h0140_0000, 32'h0000_4447, 32'h0000_0001);
        tlb_write(4'd7, 32'h0140_0000, 32'h0000_8887, 32'h0000_0001);
        ce_seen = 1'b0;
        req(1'b0, 32'h0140_0020, 32'd0);
        repeat (2) tick;
`ifdef MMU_MCHECK_EN
        total_cnt++;
        if ({ram_if.ready_o, ram_if.mcheck_o, ram_if.tlb_err_o, ce_seen} !== 4'b1100)
            $display("FAIL multi_mcheck: got rdy=%b mc=%b err=%b bus=%b exp 1 1 0 0", ram_if.ready_o, ram_if.mcheck_o, ram_if.tlb_err_o, ce_seen);
        else pass_cnt++;
`else
        total_cnt++;
        if ({bus_ce, bus_addr, ram_if.mcheck_o} !== {1'b1, 32'h0011_1020, 1'b0})
            $display("FAIL multi_lowest: got ce=%b addr=%h mc=%b exp 1 00111020 0", bus_ce, bus_addr, ram_if.mcheck_o);
        else pass_cnt++;
`endif
        end_req;
    endtask

    task test_back_to_back;
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_CAFE;
        req(1'b0, 32'h8000_2000, 32'd0);
        repeat (3) tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.data_o} !== {1'b1, 32'h0BAD_CAFE})
            $display("FAIL b2b_first: got rdy=%b data=%h exp 1 0badcafe", ram_if.ready_o, ram_if.data_o);
        else pass_cnt++;
        ram_if.addr_i = 32'h8000_4000; bus_rdata = 32'h600D_F00D;
        tick;
        total_cnt++;
        if (ram_if.ready_o !== 1'b0)
            $display("FAIL b2b_drop: got rdy=%b exp 0", ram_if.ready_o);
        else pass_cnt++;
        repeat (2) tick;
        total_cnt++;
        if ({bus_ce, bus_addr, ram_if.ready_o} !== {1'b1, 32'h0000_4000, 1'b0})
            $display("FAIL b2b_second_bus: got ce=%b addr=%h rdy=%b exp 1 00004000 0", bus_ce, bus_addr, ram_if.ready_o);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.data_o} !== {1'b1, 32'h600D_F00D})
            $display("FAIL b2b_second: got rdy=%b data=%h exp 1 600df00d", ram_if.ready_o, ram_if.data_o);
        else pass_cnt++;
        end_req;
    endtask

    task test_ce_drop;
        bus_ack = 1'b0;
        req(1'b0, 32'h8000_3000, 32'd0);
        tick;
        ram_if.ce_i = 1'b0;
        tick;
        total_cnt++;
        if ({bus_ce, bus_addr} !== {1'b1, 32'h0000_3000})
            $display("FAIL drop_issue: got ce=%b addr=%h exp 1 00003000", bus_ce, bus_addr);
        else pass_cnt++;
        repeat (2) tick;
        total_cnt++;
        if ({bus_ce, bus_addr, ram_if.ready_o} !== {1'b1, 32'h0000_3000, 1'b0})
            $display("FAIL drop_hold: got ce=%b addr=%h rdy=%b exp 1 00003000 0", bus_ce, bus_addr, ram_if.ready_o);
        else pass_cnt++;
        bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
        tick;
        total_cnt++;
        if ({ram_if.ready_o, bus_ce, ram_if.data_o} !== {1'b1, 1'b0, 32'h1357_9BDF})
            $display("FAIL drop_complete: got rdy=%b ce=%b data=%h exp 1 0 13579bdf", ram_if.ready_o, bus_ce, ram_if.data_o);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (ram_if.ready_o !== 1'b0)
            $display("FAIL drop_exit: got rdy=%b exp 0", ram_if.ready_o);
        else pass_cnt++;
        end_req;
    endtask

    task test_tlbw_same_cycle;
        tlb_write(4'd8, 32'h0008_0005, 32'h0000_1406, 32'h0);
        bus_ack = 1'b1;
        req(1'b0, 32'h0008_0010, 32'd0);
        tick;
        tlb_idx = 4'd8; ehi = 32'h0008_0005; elo0 = 32'h0000_1806; elo1 = 32'h0; tlbw = 1'b1;
        tick;
        tlbw = 1'b0;
        total_cnt++;
        if (bus_addr !== 32'h0005_0010)
            $display("FAIL tlbw_old_contents: got %h exp 00050010", bus_addr);
        else pass_cnt++;
        end_req;
        req(1'b0, 32'h0008_0010, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if (bus_addr !== 32'h0006_0010)
            $display("FAIL tlbw_new_contents: got %h exp 00060010", bus_addr);
        else pass_cnt++;
        end_req;
    endtask

    task test_reset_mid;
        bus_ack = 1'b0; asid = 8'd5;
        tlb_write(4'd3, 32'h0040_0005, 32'h0, 32'h0000_48C6);
        req(1'b0, 32'h0040_1ABC, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if (bus_ce !== 1'b1)
            $display("FAIL rst_mid_setup: got ce=%b exp 1", bus_ce);
        else pass_cnt++;
        rst = 1'b1; ram_if.ce_i = 1'b0;
        tlb_idx = 4'd9; ehi = 32'h0090_0005; elo0 = 32'h0000_0006; elo1 = 32'h0; tlbw = 1'b1;
        tick;
        rst = 1'b0; tlbw = 1'b0; bus_ack = 1'b1;
        total_cnt++;
        if ({bus_ce, ram_if.ready_o, bus_addr, ram_if.data_o} !== 66'd0)
            $display("FAIL rst_mid_outputs: got ce=%b rdy=%b addr=%h data=%h exp 0", bus_ce, ram_if.ready_o, bus_addr, ram_if.data_o);
        else pass_cnt++;
        ce_seen = 1'b0;
        req(1'b0, 32'h0040_1ABC, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.tlb_err_o, ce_seen} !== 3'b110)
            $display("FAIL rst_clears_tlb: got rdy=%b err=%b bus=%b exp 1 1 0", ram_if.ready_o, ram_if.tlb_err_o, ce_seen);
        else pass_cnt++;
        end_req;
        ce_seen = 1'b0;
        req(1'b0, 32'h0090_0000, 32'd0);
        repeat (2) tick;
        total_cnt++;
        if ({ram_if.ready_o, ram_if.tlb_err_o, ce_seen} !== 3'b110)
            $display("FAIL rst_beats_tlbw: got rdy=%b err=%b bus=%b exp 1 1 0", ram_if.ready_o, ram_if.tlb_err_o, ce_seen);
        else pass_cnt++;
        end_req;
    endtask

    initial begin
        rst = 1'b1; asid = 8'd0; tlbw = 1'b0; tlb_idx = 4'd0;
        ehi = 32'd0; elo0 = 32'd0; elo1 = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0; ce_seen = 1'b0;
        ram_if.ce_i = 1'b0; ram_if.we_i = 1'b0; ram_if.addr_i = 32'd0; ram_if.data_i = 32'd0;
        test_reset;
        test_unmapped_read;
        test_unmapped_write;
        test_mapped;
        test_asid_miss;
        test_mod;
        test_global;
        test_multi;
        test_back_to_back;
        test_ce_drop;
        test_tlbw_same_cycle;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
